// File: rtl/command_decoder_pkg.sv
// TitanComms shared definitions: opcode set, decoder states and the
// frame-length lookup used to size each command frame.
package command_decoder_pkg;

    typedef enum logic [7:0] {
        OP_WRITE              = 8'h01,
        OP_READ               = 8'h02,
        OP_STREAM             = 8'h03,
        OP_TRANSFER           = 8'h04,
        OP_REPEAT             = 8'h05,
        OP_BIND_INTERRUPT     = 8'h06,
        OP_BIND_READ_ADDRESS  = 8'h07,
        OP_BIND_WRITE_ADDRESS = 8'h08
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ISSUE
    } decoder_state_t;

    localparam int COUNT_WIDTH = 5;

    // Total frame length including the opcode byte; 0 marks an unknown opcode.
    function automatic int frame_bytes(input logic [7:0] opcode, input int ab, input int vb);
        int n;
        n = 0;
        case (opcode)
            OP_WRITE:                   n = 1 + ab + vb;
            OP_READ,
            OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS:      n = 1 + ab;
            OP_STREAM:                  n = 1 + vb;
            OP_TRANSFER, OP_REPEAT:     n = 1;
            default:                    n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/command_decoder_tx_byte_sel.sv
// Registered MSB-first byte selector feeding the SPI transmit byte; one
// snapshot register and pointer shared by TRANSFER readback and STREAM.
module command_decoder_tx_byte_sel #(
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   transfer_i,
    input  logic                   repeat_i,
    input  logic                   stream_start_i,
    input  logic                   stream_step_i,
    input  logic [VALUE_WIDTH-1:0] core_value_i,
    input  logic [VALUE_WIDTH-1:0] stream_value_i,
    output logic [7:0]             tx_byte_o
);
    localparam int VB = VALUE_WIDTH / 8;
    localparam int PW = (VB > 1) ? $clog2(VB) : 1;
    localparam logic [PW-1:0] LAST = PW'(VB - 1);

    logic [VALUE_WIDTH-1:0] snap_q, snap_d;
    logic [PW-1:0]          ptr_q, ptr_d, ptr_next;
    logic [7:0]             tx_q, tx_d;

    function automatic logic [7:0] byte_at(input logic [VALUE_WIDTH-1:0] v, input logic [PW-1:0] p);
        return v[(VB - 1 - int'(p)) * 8 +: 8];
    endfunction

    always_comb begin
        snap_d   = snap_q;
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        ptr_next = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
        if (repeat_i) begin
            ptr_d = '0;
            tx_d  = 8'h00;
        end else if (transfer_i) begin
            // A readback pass restarting at byte 0 takes a fresh snapshot.
            if (ptr_q == '0) begin
                snap_d = core_value_i;
                tx_d   = core_value_i[VALUE_WIDTH-1 -: 8];
            end else begin
                tx_d = byte_at(snap_q, ptr_q);
            end
            ptr_d = ptr_next;
        end else if (stream_start_i) begin
            snap_d = stream_value_i;
            tx_d   = stream_value_i[VALUE_WIDTH-1 -: 8];
            ptr_d  = (LAST == '0) ? '0 : PW'(1);
        end else if (stream_step_i) begin
            // Pointer back at 0 means every snapshot byte has been shifted out.
            if (ptr_q == '0) begin
                tx_d = 8'h00;
            end else begin
                tx_d  = byte_at(snap_q, ptr_q);
                ptr_d = ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            ptr_q  <= '0;
            tx_q   <= 8'h00;
        end else begin
            snap_q <= snap_d;
            ptr_q  <= ptr_d;
            tx_q   <= tx_d;
        end
    end

    assign tx_byte_o = tx_q;

endmodule

// File: rtl/command_decoder.sv
// TitanComms command decoder: rebuilds SPI command frames byte by byte and
// issues each complete command on a ready/valid bus to the core.
module command_decoder
    import command_decoder_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32,
    parameter int INSTRUCTION_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_frame_active,
    input  logic                     spi_rx_valid,
    input  logic [7:0]               spi_rx_byte,
    input  logic [VALUE_WIDTH-1:0]   value_from_core,
    input  logic [VALUE_WIDTH-1:0]   stream_bus,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               instruction_bus,
    output logic [ADDRESS_WIDTH-1:0] address_bus,
    output logic [VALUE_WIDTH-1:0]   value_bus,
    output logic [7:0]               spi_tx_byte,
    output logic                     err_opcode,
    output logic                     err_overrun,
    output logic                     err_abort
);
    localparam int AB = ADDRESS_WIDTH / 8;
    localparam int VB = VALUE_WIDTH / 8;
    localparam int FW = ADDRESS_WIDTH + VALUE_WIDTH;

    if (INSTRUCTION_WIDTH != 8) begin : g_bad_instruction_width
        $error("command_decoder: INSTRUCTION_WIDTH must be 8");
    end
    if ((ADDRESS_WIDTH % 8 != 0) || (ADDRESS_WIDTH < 8) || (ADDRESS_WIDTH > 32) ||
        (VALUE_WIDTH % 8 != 0) || (VALUE_WIDTH < 8) || (VALUE_WIDTH > 64)) begin : g_bad_field_width
        $error("command_decoder: unsupported ADDRESS_WIDTH/VALUE_WIDTH");
    end

    decoder_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [7:0]               opcode_q, opcode_d;
    logic [FW-1:0]            field_q, field_d;
    logic                     frame_active_q, frame_active_d;
    logic                     cmd_valid_q, cmd_valid_d;
    logic [7:0]               instruction_q, instruction_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [VALUE_WIDTH-1:0]   value_q, value_d;
    logic                     err_opcode_q, err_opcode_d;
    logic                     err_overrun_q, err_overrun_d;
    logic                     err_abort_q, err_abort_d;

    logic          do_transfer, do_repeat, do_stream_start, do_stream_step;
    logic          frame_fall;
    logic [FW-1:0] assembled;
    int            rx_frame_bytes;

    assign frame_fall = frame_active_q && !spi_frame_active;

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        opcode_d        = opcode_q;
        field_d         = field_q;
        frame_active_d  = spi_frame_active;
        cmd_valid_d     = cmd_valid_q;
        instruction_d   = instruction_q;
        address_d       = address_q;
        value_d         = value_q;
        err_opcode_d    = 1'b0;
        err_overrun_d   = 1'b0;
        err_abort_d     = 1'b0;
        do_transfer     = 1'b0;
        do_repeat       = 1'b0;
        do_stream_start = 1'b0;
        do_stream_step  = 1'b0;
        assembled       = {field_q[FW-9:0], spi_rx_byte};
        rx_frame_bytes  = frame_bytes(spi_rx_byte, AB, VB);

        unique case (state_q)
            IDLE: begin
                if (spi_rx_valid) begin
                    if (spi_rx_byte == OP_TRANSFER) begin
                        do_transfer = 1'b1;
                    end else if (spi_rx_byte == OP_REPEAT) begin
                        do_repeat = 1'b1;
                    end else if (rx_frame_bytes == 0) begin
                        err_opcode_d = 1'b1;
                    end else begin
                        opcode_d        = spi_rx_byte;
                        remaining_d     = COUNT_WIDTH'(rx_frame_bytes - 1);
                        field_d         = '0;
                        state_d         = COLLECT;
                        do_stream_start = (spi_rx_byte == OP_STREAM);
                    end
                end
            end
            COLLECT: begin
                // A frame ending mid-command wins over a byte on the same cycle.
                if (frame_fall) begin
                    state_d     = IDLE;
                    field_d     = '0;
                    err_abort_d = 1'b1;
                end else if (spi_rx_valid) begin
                    field_d        = assembled;
                    remaining_d    = remaining_q - COUNT_WIDTH'(1);
                    do_stream_step = (opcode_q == OP_STREAM);
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_d       = ISSUE;
                        cmd_valid_d   = 1'b1;
                        instruction_d = opcode_q;
                        address_d     = '0;
                        value_d       = '0;
                        case (opcode_q)
                            OP_WRITE: begin
                                address_d = assembled[FW-1 -: ADDRESS_WIDTH];
                                value_d   = assembled[VALUE_WIDTH-1:0];
                            end
                            OP_STREAM: value_d   = assembled[VALUE_WIDTH-1:0];
                            default:   address_d = assembled[ADDRESS_WIDTH-1:0];
                        endcase
                    end
                end
            end
            ISSUE: begin
                err_overrun_d = spi_rx_valid;
                if (cmd_ready) begin
                    state_d     = IDLE;
                    cmd_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            opcode_q       <= 8'h00;
            field_q        <= '0;
            frame_active_q <= 1'b0;
            cmd_valid_q    <= 1'b0;
            instruction_q  <= 8'h00;
            address_q      <= '0;
            value_q        <= '0;
            err_opcode_q   <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_abort_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            opcode_q       <= opcode_d;
            field_q        <= field_d;
            frame_active_q <= frame_active_d;
            cmd_valid_q    <= cmd_valid_d;
            instruction_q  <= instruction_d;
            address_q      <= address_d;
            value_q        <= value_d;
            err_opcode_q   <= err_opcode_d;
            err_overrun_q  <= err_overrun_d;
            err_abort_q    <= err_abort_d;
        end
    end

    command_decoder_tx_byte_sel #(
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_tx_byte_sel (
        .clk            (clk),
        .rst_n          (rst_n),
        .transfer_i     (do_transfer),
        .repeat_i       (do_repeat),
        .stream_start_i (do_stream_start),
        .stream_step_i  (do_stream_step),
        .core_value_i   (value_from_core),
        .stream_value_i (stream_bus),
        .tx_byte_o      (spi_tx_byte)
    );

    assign cmd_valid       = cmd_valid_q;
    assign instruction_bus = instruction_q;
    assign address_bus     = address_q;
    assign value_bus       = value_q;
    assign err_opcode      = err_opcode_q;
    assign err_overrun     = err_overrun_q;
    assign err_abort       = err_abort_q;

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: default 24/32-bit instance plus a
// 16/64-bit instance for the wide-frame and asynchronous-reset scenarios.
module tb_command_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    logic        spi_frame_active = 1'b0;
    logic        spi_rx_valid = 1'b0;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic [31:0] value_from_core = '0;
    logic [31:0] stream_bus = '0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [7:0]  instruction_bus;
    logic [23:0] address_bus;
    logic [31:0] value_bus;
    logic [7:0]  spi_tx_byte;
    logic        err_opcode, err_overrun, err_abort;

    logic        frame_w = 1'b0;
    logic        rx_valid_w = 1'b0;
    logic [7:0]  rx_byte_w = 8'h00;
    logic [63:0] core_w = '0;
    logic [63:0] stream_w = '0;
    logic        ready_w = 1'b1;
    logic        valid_w;
    logic [7:0]  instr_w;
    logic [15:0] addr_w;
    logic [63:0] value_w;
    logic [7:0]  tx_w;
    logic        err_opcode_w, err_overrun_w, err_abort_w;

    always #5 clk = ~clk;

    command_decoder dut (
        .clk(clk), .rst_n(rst_n), .spi_frame_active(spi_frame_active),
        .spi_rx_valid(spi_rx_valid), .spi_rx_byte(spi_rx_byte),
        .value_from_core(value_from_core), .stream_bus(stream_bus),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .instruction_bus(instruction_bus),
        .address_bus(address_bus), .value_bus(value_bus), .spi_tx_byte(spi_tx_byte),
        .err_opcode(err_opcode), .err_overrun(err_overrun), .err_abort(err_abort)
    );

    command_decoder #(.ADDRESS_WIDTH(16), .VALUE_WIDTH(64)) dut_w (
        .clk(clk), .rst_n(rst_n), .spi_frame_active(frame_w),
        .spi_rx_valid(rx_valid_w), .spi_rx_byte(rx_byte_w),
        .value_from_core(core_w), .stream_bus(stream_w),
        .cmd_valid(valid_w), .cmd_ready(ready_w), .instruction_bus(instr_w),
        .address_bus(addr_w), .value_bus(value_w), .spi_tx_byte(tx_w),
        .err_opcode(err_opcode_w), .err_overrun(err_overrun_w), .err_abort(err_abort_w)
    );

    // Called at a falling edge; strobes one byte across the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        spi_rx_valid = 1'b1;
        spi_rx_byte  = b;
        @(negedge clk);
        spi_rx_valid = 1'b0;
    endtask

    task automatic send_byte_w(input logic [7:0] b);
        rx_valid_w = 1'b1;
        rx_byte_w  = b;
        @(negedge clk);
        rx_valid_w = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus, spi_tx_byte, err_opcode, err_overrun, err_abort} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%0b instr=%h addr=%h value=%h tx=%h err=%b%b%b expected all 0",
                     cmd_valid, instruction_bus, address_bus, value_bus, spi_tx_byte, err_opcode, err_overrun, err_abort);
        end
        @(negedge clk);
        rst_n = 1'b1;
        spi_frame_active = 1'b1;
        frame_w = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        cmd_ready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        compared++;
        if (cmd_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL write_early_valid: got %0b expected 0", cmd_valid);
        end
        send_byte(8'hEF);
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus} !== {1'b1, 8'h01, 24'h012345, 32'hDEADBEEF}) begin
            mismatched++;
            $display("[TB] FAIL write_cmd: got valid=%0b instr=%h addr=%h value=%h expected 1/01/012345/deadbeef",
                     cmd_valid, instruction_bus, address_bus, value_bus);
        end
        @(negedge clk);
        compared++;
        if (cmd_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL write_pulse_len: got valid=%0b expected 0", cmd_valid);
        end
    endtask

    task automatic test_read_hold;
        cmd_ready = 1'b0;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus} !== {1'b1, 8'h02, 24'h00ABCD, 32'h0}) begin
            mismatched++;
            $display("[TB] FAIL read_cmd: got valid=%0b instr=%h addr=%h value=%h expected 1/02/00abcd/0",
                     cmd_valid, instruction_bus, address_bus, value_bus);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if ({cmd_valid, address_bus} !== {1'b1, 24'h00ABCD}) begin
                mismatched++; $display("[TB] FAIL read_hold: got valid=%0b addr=%h expected 1/00abcd", cmd_valid, address_bus);
            end
        end
        send_byte(8'h99);
        compared++;
        if ({err_overrun, cmd_valid, instruction_bus, address_bus} !== {1'b1, 1'b1, 8'h02, 24'h00ABCD}) begin
            mismatched++;
            $display("[TB] FAIL read_overrun: got ovr=%0b valid=%0b instr=%h addr=%h expected 1/1/02/00abcd",
                     err_overrun, cmd_valid, instruction_bus, address_bus);
        end
        @(negedge clk);
        compared++;
        if ({err_overrun, cmd_valid} !== 2'b01) begin
            mismatched++; $display("[TB] FAIL read_overrun_pulse: got ovr=%0b valid=%0b expected 0/1", err_overrun, cmd_valid);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (cmd_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL read_release: got valid=%0b expected 0", cmd_valid);
        end
    endtask

    task automatic test_transfer;
        logic [7:0] exp_tx [5];
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        value_from_core = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) value_from_core = 32'hCAFEF00D;
            if (i == 4) value_from_core = 32'h11223344;
            send_byte(8'h04);
            compared++;
            if ({spi_tx_byte, cmd_valid} !== {exp_tx[i], 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL transfer_%0d: got tx=%h valid=%0b expected %h/0", i, spi_tx_byte, cmd_valid, exp_tx[i]);
            end
        end
        send_byte(8'h05);
        compared++;
        if (spi_tx_byte !== 8'h00) begin
            mismatched++; $display("[TB] FAIL repeat_tx: got %h expected 00", spi_tx_byte);
        end
        send_byte(8'h04);
        compared++;
        if (spi_tx_byte !== 8'h11) begin
            mismatched++; $display("[TB] FAIL repeat_transfer: got %h expected 11", spi_tx_byte);
        end
    endtask

    task automatic test_stream;
        logic [7:0] rx_seq [5];
        logic [7:0] exp_tx [5];
        rx_seq = '{8'h03, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
        stream_bus = 32'hA1B2C3D4;
        for (int i = 0; i < 5; i++) begin
            send_byte(rx_seq[i]);
            if (i == 0) stream_bus = 32'h0BADBAD0;
            compared++;
            if (spi_tx_byte !== exp_tx[i]) begin
                mismatched++; $display("[TB] FAIL stream_tx_%0d: got %h expected %h", i, spi_tx_byte, exp_tx[i]);
            end
        end
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus} !== {1'b1, 8'h03, 24'h0, 32'h55667788}) begin
            mismatched++;
            $display("[TB] FAIL stream_cmd: got valid=%0b instr=%h addr=%h value=%h expected 1/03/000000/55667788",
                     cmd_valid, instruction_bus, address_bus, value_bus);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        spi_frame_active = 1'b0;
        @(negedge clk);
        compared++;
        if ({err_abort, cmd_valid} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL abort_pulse: got abort=%0b valid=%0b expected 1/0", err_abort, cmd_valid);
        end
        spi_frame_active = 1'b1;
        @(negedge clk);
        compared++;
        if ({err_abort, cmd_valid} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL abort_after: got abort=%0b valid=%0b expected 0/0", err_abort, cmd_valid);
        end
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus} !== {1'b1, 8'h02, 24'h123456, 32'h0}) begin
            mismatched++;
            $display("[TB] FAIL abort_next_read: got valid=%0b instr=%h addr=%h value=%h expected 1/02/123456/0",
                     cmd_valid, instruction_bus, address_bus, value_bus);
        end
        @(negedge clk);
    endtask

    task automatic test_wide;
        ready_w = 1'b1;
        send_byte_w(8'h01); send_byte_w(8'h12); send_byte_w(8'h34);
        for (int i = 1; i <= 7; i++) send_byte_w(8'(i));
        compared++;
        if (valid_w !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wide_early_valid: got %0b expected 0", valid_w);
        end
        send_byte_w(8'h08);
        compared++;
        if ({valid_w, instr_w, addr_w, value_w} !== {1'b1, 8'h01, 16'h1234, 64'h0102030405060708}) begin
            mismatched++;
            $display("[TB] FAIL wide_write: got valid=%0b instr=%h addr=%h value=%h expected 1/01/1234/0102030405060708",
                     valid_w, instr_w, addr_w, value_w);
        end
        @(negedge clk);
        send_byte_w(8'hFF);
        compared++;
        if ({err_opcode_w, valid_w} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL wide_bad_opcode: got err=%0b valid=%0b expected 1/0", err_opcode_w, valid_w);
        end
        send_byte_w(8'h02); send_byte_w(8'hAB);
        compared++;
        if (err_opcode_w !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wide_opcode_pulse: got %0b expected 0", err_opcode_w);
        end
        send_byte_w(8'hCD);
        compared++;
        if ({valid_w, instr_w, addr_w, value_w} !== {1'b1, 8'h02, 16'hABCD, 64'h0}) begin
            mismatched++;
            $display("[TB] FAIL wide_read_after_bad: got valid=%0b instr=%h addr=%h value=%h expected 1/02/abcd/0",
                     valid_w, instr_w, addr_w, value_w);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        core_w = 64'h8877665544332211;
        send_byte_w(8'h04);
        compared++;
        if (tx_w !== 8'h88) begin
            mismatched++; $display("[TB] FAIL wide_transfer: got %h expected 88", tx_w);
        end
        send_byte_w(8'h01); send_byte_w(8'h55); send_byte_w(8'h66);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({valid_w, instr_w, addr_w, value_w, tx_w, err_opcode_w, err_overrun_w, err_abort_w} !== '0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_wide: got valid=%0b instr=%h addr=%h value=%h tx=%h expected all 0",
                     valid_w, instr_w, addr_w, value_w, tx_w);
        end
        compared++;
        if ({cmd_valid, instruction_bus, address_bus, value_bus, spi_tx_byte} !== '0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_default: got valid=%0b instr=%h addr=%h value=%h tx=%h expected all 0",
                     cmd_valid, instruction_bus, address_bus, value_bus, spi_tx_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        core_w = 64'hF0E1D2C3B4A59687;
        send_byte_w(8'h04);
        compared++;
        if ({tx_w, err_abort_w} !== {8'hF0, 1'b0}) begin
            mismatched++; $display("[TB] FAIL reset_pointer: got tx=%h abort=%0b expected f0/0", tx_w, err_abort_w);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_transfer();
        test_stream();
        test_abort();
        test_wide();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
